// File: rtl/link_watchdog_pkg.sv
// Shared types and default command bytes for the link watchdog.
// Also holds the reply length and the status-byte packing helper.
package link_watchdog_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } reply_state_t;

  typedef enum logic {
    RUN   = 1'b0,
    PULSE = 1'b1
  } rst_state_t;

  localparam logic [7:0] DEF_PING_CMD  = 8'hAE;
  localparam logic [7:0] DEF_RST_CMD   = 8'hF0;
  localparam logic [7:0] DEF_REPLY_HDR = 8'hEA;

  localparam logic [7:0] REPLY_LEN      = 8'd3;
  localparam logic [1:0] REPLY_LAST_IDX = 2'd2;

  function automatic logic [7:0] pack_status(input logic overrun,
                                             input logic link_lost,
                                             input logic rst_seen);
    return {5'b0, overrun, link_lost, rst_seen};
  endfunction

endpackage

// File: rtl/link_watchdog_pulse_timer.sv
// Loadable down-counter; busy stays high until the loaded count has drained to zero.
module pulse_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             busy
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/link_watchdog.sv
// Keep-alive watchdog: answers pings with a 3-byte reply, tracks ping timeout,
// and drives a fixed-width active-low external reset pulse on request.
module link_watchdog
  import link_watchdog_pkg::*;
#(
  parameter logic [7:0] PING_CMD  = DEF_PING_CMD,
  parameter logic [7:0] RST_CMD   = DEF_RST_CMD,
  parameter logic [7:0] REPLY_HDR = DEF_REPLY_HDR,
  parameter int         RST_PULSE = 16,
  parameter int         TIMEOUT   = 1000000,
  parameter bit         AUTO_RST  = 1'b0
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [7:0] data,
  input  logic       ena,
  output logic       have_msg,
  input  logic       rdreq,
  output logic [7:0] data_out,
  output logic [7:0] len,
  output logic       n_rst_ext,
  output logic       link_lost
);

  localparam int             WD_W   = $clog2(TIMEOUT);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT - 1);
  localparam int             PT_W   = $clog2(RST_PULSE + 1);
  // The timer drains one cycle after its load value, hence the -1.
  localparam logic [PT_W-1:0] PT_LOAD = PT_W'(RST_PULSE - 1);

  reply_state_t reply_state;
  rst_state_t   rst_state;

  logic [1:0]      idx;
  logic [7:0]      seq_cnt;
  logic            overrun;
  logic            rst_seen;
  logic [7:0]      seq_lat;
  logic [7:0]      status_lat;
  logic [WD_W-1:0] wd_cnt;

  logic ping;
  logic rst_cmd;
  logic accept;
  logic ping_busy;
  logic timeout_evt;
  logic rst_trig;
  logic pulse_start;
  logic pulse_busy;

  assign ping      = ena && (data == PING_CMD);
  assign rst_cmd   = ena && (data == RST_CMD);
  assign accept    = ping && (reply_state == IDLE);
  assign ping_busy = ping && (reply_state == SEND);

  // link_lost doubles as the once-per-loss guard on the timeout event.
  assign timeout_evt = (wd_cnt == WD_MAX) && !link_lost && !ping;
  assign rst_trig    = rst_cmd || (AUTO_RST && timeout_evt);
  assign pulse_start = (rst_state == RUN) && rst_trig;

  assign len = REPLY_LEN;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      wd_cnt    <= '0;
      link_lost <= 1'b0;
    end else if (ping) begin
      wd_cnt    <= '0;
      link_lost <= 1'b0;
    end else begin
      if (wd_cnt != WD_MAX) begin
        wd_cnt <= wd_cnt + 1'b1;
      end
      if (timeout_evt) begin
        link_lost <= 1'b1;
      end
    end
  end

  pulse_timer #(
    .CNT_W (PT_W)
  ) u_pulse_timer (
    .clk      (clk),
    .n_rst    (n_rst),
    .load     (pulse_start),
    .load_val (PT_LOAD),
    .busy     (pulse_busy)
  );

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      rst_state <= RUN;
      n_rst_ext <= 1'b1;
    end else begin
      case (rst_state)
        RUN: begin
          if (rst_trig) begin
            rst_state <= PULSE;
            n_rst_ext <= 1'b0;
          end
        end
        PULSE: begin
          if (!pulse_busy) begin
            rst_state <= RUN;
            n_rst_ext <= 1'b1;
          end
        end
        default: begin
          rst_state <= RUN;
          n_rst_ext <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      reply_state <= IDLE;
      idx         <= 2'd0;
      have_msg    <= 1'b0;
      seq_cnt     <= 8'd0;
    end else begin
      case (reply_state)
        IDLE: begin
          if (accept) begin
            reply_state <= SEND;
            idx         <= 2'd0;
            have_msg    <= 1'b1;
            seq_cnt     <= seq_cnt + 8'd1;
          end
        end
        SEND: begin
          if (rdreq) begin
            if (idx == REPLY_LAST_IDX) begin
              reply_state <= IDLE;
              idx         <= 2'd0;
              have_msg    <= 1'b0;
            end else begin
              idx <= idx + 2'd1;
            end
          end
        end
        default: begin
          reply_state <= IDLE;
          idx         <= 2'd0;
          have_msg    <= 1'b0;
        end
      endcase
    end
  end

  // Sticky flags: a new event in the same cycle as a latch must survive.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      overrun  <= 1'b0;
      rst_seen <= 1'b0;
    end else begin
      if (ping_busy) begin
        overrun <= 1'b1;
      end else if (accept) begin
        overrun <= 1'b0;
      end
      if (pulse_start) begin
        rst_seen <= 1'b1;
      end else if (accept) begin
        rst_seen <= 1'b0;
      end
    end
  end

  // Reply payload is only visible in SEND, which always follows a latch.
  always_ff @(posedge clk) begin
    if (accept) begin
      seq_lat    <= seq_cnt;
      status_lat <= pack_status(overrun, link_lost, rst_seen);
    end
  end

  always_comb begin
    data_out = REPLY_HDR;
    if (reply_state == SEND) begin
      case (idx)
        2'd1:    data_out = seq_lat;
        2'd2:    data_out = status_lat;
        default: data_out = REPLY_HDR;
      endcase
    end
  end

endmodule

// File: tb/tb_link_watchdog.sv
// Scoreboard bench for link_watchdog: reply bytes are queued at stimulus time
// and popped by a negedge monitor whenever a byte is read out.
module tb_link_watchdog;

  logic       clk = 1'b0;
  logic       n_rst;
  logic [7:0] data;
  logic       ena;
  logic       rdreq;
  logic       have_msg;
  logic [7:0] data_out;
  logic [7:0] len;
  logic       n_rst_ext;
  logic       link_lost;

  logic       b_n_rst;
  logic [7:0] b_data;
  logic       b_ena;
  logic       b_rdreq;
  logic       b_have_msg;
  logic [7:0] b_data_out;
  logic [7:0] b_len;
  logic       b_n_rst_ext;
  logic       b_link_lost;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  link_watchdog #(
    .RST_PULSE (16),
    .TIMEOUT   (100000),
    .AUTO_RST  (1'b0)
  ) dut_a (
    .clk       (clk),
    .n_rst     (n_rst),
    .data      (data),
    .ena       (ena),
    .have_msg  (have_msg),
    .rdreq     (rdreq),
    .data_out  (data_out),
    .len       (len),
    .n_rst_ext (n_rst_ext),
    .link_lost (link_lost)
  );

  link_watchdog #(
    .RST_PULSE (4),
    .TIMEOUT   (8),
    .AUTO_RST  (1'b1)
  ) dut_b (
    .clk       (clk),
    .n_rst     (b_n_rst),
    .data      (b_data),
    .ena       (b_ena),
    .have_msg  (b_have_msg),
    .rdreq     (b_rdreq),
    .data_out  (b_data_out),
    .len       (b_len),
    .n_rst_ext (b_n_rst_ext),
    .link_lost (b_link_lost)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic ping();
    data = 8'hAE;
    ena  = 1'b1;
    cyc();
    ena  = 1'b0;
    data = 8'h00;
  endtask

  task automatic read_reply(input logic [7:0] s, input logic [7:0] st, input bit ping_last);
    exp_q.push_back(8'hEA);
    exp_q.push_back(s);
    exp_q.push_back(st);
    rdreq = 1'b1;
    cyc();
    cyc();
    if (ping_last) begin
      data = 8'hAE;
      ena  = 1'b1;
    end
    cyc();
    rdreq = 1'b0;
    ena   = 1'b0;
    data  = 8'h00;
    check("have_msg_after_read", {15'd0, have_msg}, 16'd0);
  endtask

  task automatic do_reply(input logic [7:0] s, input logic [7:0] st);
    ping();
    check("have_msg_after_ping", {15'd0, have_msg}, 16'd1);
    read_reply(s, st, 1'b0);
  endtask

  always @(negedge clk) begin
    if (n_rst && rdreq && have_msg) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL reply_unexpected: got %h expected none", data_out);
      end else begin
        check("reply_byte", {8'd0, data_out}, {8'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int low_cnt;
    int first_lost;

    n_rst   = 1'b0;
    data    = 8'h00;
    ena     = 1'b0;
    rdreq   = 1'b0;
    b_n_rst = 1'b0;
    b_data  = 8'h00;
    b_ena   = 1'b0;
    b_rdreq = 1'b0;
    repeat (3) cyc();

    check("rst_have_msg", {15'd0, have_msg}, 16'd0);
    check("rst_n_rst_ext", {15'd0, n_rst_ext}, 16'd1);
    check("rst_link_lost", {15'd0, link_lost}, 16'd0);
    check("rst_data_out", {8'd0, data_out}, 16'h00EA);
    check("len_const", {8'd0, len}, 16'd3);
    n_rst = 1'b1;
    cyc();

    do_reply(8'h00, 8'h00);

    // rdreq with nothing pending must not disturb anything
    rdreq = 1'b1;
    cyc();
    rdreq = 1'b0;
    check("idle_rdreq_have_msg", {15'd0, have_msg}, 16'd0);
    do_reply(8'h01, 8'h00);

    // ping during SEND: overrun, reply unchanged
    ping();
    ping();
    read_reply(8'h02, 8'h00, 1'b0);
    do_reply(8'h03, 8'h04);
    do_reply(8'h04, 8'h00);

    // ping coinciding with the last byte read counts as overrun
    ping();
    read_reply(8'h05, 8'h00, 1'b1);
    do_reply(8'h06, 8'h04);

    // unrelated byte with ena, ping byte without ena
    data = 8'h55;
    ena  = 1'b1;
    cyc();
    ena  = 1'b0;
    data = 8'hAE;
    cyc();
    data = 8'h00;
    check("ignored_bytes_have_msg", {15'd0, have_msg}, 16'd0);

    // external reset pulse, second request mid-pulse must not extend it
    data = 8'hF0;
    ena  = 1'b1;
    cyc();
    ena  = 1'b0;
    low_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (n_rst_ext == 1'b0) low_cnt++;
      if (i == 4) begin
        data = 8'hF0;
        ena  = 1'b1;
      end else begin
        ena  = 1'b0;
        data = 8'h00;
      end
      cyc();
    end
    ena  = 1'b0;
    check("pulse_width", 16'(low_cnt), 16'd16);
    check("pulse_end_high", {15'd0, n_rst_ext}, 16'd1);
    do_reply(8'h07, 8'h01);
    do_reply(8'h08, 8'h00);

    // seq wrap from a fresh reset
    n_rst = 1'b0;
    cyc();
    n_rst = 1'b1;
    for (int i = 0; i < 257; i++) begin
      do_reply(8'(i), 8'h00);
    end

    // reset while both a reply and a pulse are active
    ping();
    data = 8'hF0;
    ena  = 1'b1;
    cyc();
    ena  = 1'b0;
    data = 8'h00;
    check("mid_have_msg", {15'd0, have_msg}, 16'd1);
    check("mid_n_rst_ext", {15'd0, n_rst_ext}, 16'd0);
    n_rst = 1'b0;
    cyc();
    check("abort_n_rst_ext", {15'd0, n_rst_ext}, 16'd1);
    check("abort_have_msg", {15'd0, have_msg}, 16'd0);
    n_rst = 1'b1;
    do_reply(8'h00, 8'h00);

    // timeout with auto reset on the second instance
    check("b_len", {8'd0, b_len}, 16'd3);
    check("b_rst_data_out", {8'd0, b_data_out}, 16'h00EA);
    b_n_rst = 1'b1;
    low_cnt    = 0;
    first_lost = 0;
    for (int i = 1; i <= 30; i++) begin
      cyc();
      if (b_link_lost && first_lost == 0) first_lost = i;
      if (!b_n_rst_ext) low_cnt++;
    end
    check("b_lost_cycle", 16'(first_lost), 16'd8);
    check("b_single_pulse", 16'(low_cnt), 16'd4);
    check("b_lost_held", {15'd0, b_link_lost}, 16'd1);
    b_data = 8'hAE;
    b_ena  = 1'b1;
    cyc();
    b_ena  = 1'b0;
    b_data = 8'h00;
    check("b_lost_cleared", {15'd0, b_link_lost}, 16'd0);
    check("b_have_msg", {15'd0, b_have_msg}, 16'd1);

    check("scoreboard_drained", 16'(exp_q.size()), 16'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
